// File: rtl/relay_encode.sv
// relay_encode: queues relay nibbles as single bits and transmits each as a WINDOW-clock
// chip on a serial line, preceded by one start chip per transmit session.
module relay_encode #(
    parameter int WINDOW = 64,
    parameter int DEPTH  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       in_ready,
    input  logic       tx_en,
    output logic       data_out,
    output logic       busy,
    output logic       bit_strobe,
    output logic       underrun,
    output logic [4:0] fifo_count
);
    localparam int CW = $clog2(WINDOW);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_CHIP  = CW'(WINDOW - 1);
    localparam logic [4:0]    FULL_COUNT = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SEND
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_chip;
    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [4:0]       r_count;
    logic             r_data_out;
    logic             r_busy;
    logic             r_strobe;
    logic             r_underrun;

    logic w_bit;
    logic w_push;
    logic w_pop;
    logic w_not_empty;
    logic w_window_end;
    logic w_unused;

    assign w_bit        = &data_in[3:2];
    // The low two nibble bits never influence the line value.
    assign w_unused     = ^data_in[1:0];
    assign in_ready     = (r_count != FULL_COUNT);
    assign w_not_empty  = (r_count != 5'd0);
    assign w_push       = data_valid && in_ready;
    assign w_window_end = (r_state != IDLE) && (r_chip == LAST_CHIP);
    // Uses the pre-edge count, so a push on this same edge cannot rescue an empty FIFO.
    assign w_pop        = w_window_end && tx_en && w_not_empty;

    // NOTE: the bit storage has no reset; pointers and count alone define valid entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_bit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_chip     <= '0;
            r_data_out <= 1'b0;
            r_busy     <= 1'b0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_chip     <= '0;
                    r_data_out <= 1'b0;
                    r_busy     <= 1'b0;
                    if (tx_en && w_not_empty) begin
                        r_state    <= START;
                        r_data_out <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                START, SEND: begin
                    if (r_chip == LAST_CHIP) begin
                        r_chip <= '0;
                        if (!tx_en) begin
                            r_state    <= IDLE;
                            r_data_out <= 1'b0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_state  <= SEND;
                            r_strobe <= 1'b1;
                            if (w_not_empty) begin
                                r_data_out <= r_mem[r_rd_ptr];
                            end else begin
                                r_data_out <= 1'b0;
                                r_underrun <= 1'b1;
                            end
                        end
                    end else begin
                        r_chip <= r_chip + 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_chip     <= '0;
                    r_data_out <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign busy       = r_busy;
    assign bit_strobe = r_strobe;
    assign underrun   = r_underrun;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_relay_encode.sv
// Bench for relay_encode: queue-based window model feeding a scoreboard, directed
// latency/boundary scenarios, then a randomized traffic phase.
module tb_relay_encode;
    localparam int WINDOW = 64;
    localparam int DEPTH  = 8;

    typedef struct packed {
        logic bit_v;
        logic filler;
    } win_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic       data_valid = 1'b0;
    logic       tx_en = 1'b0;
    logic       in_ready;
    logic       data_out;
    logic       busy;
    logic       bit_strobe;
    logic       underrun;
    logic [4:0] fifo_count;

    int checks = 0;
    int failures = 0;
    int n_data_win = 0;
    int cyc = 0;

    // Reference model state: queued bits, expected windows, current line behaviour.
    bit   m_q[$];
    win_t exp_q[$];
    bit   m_active = 1'b0;
    int   m_left = 0;
    bit   m_line = 1'b0;
    bit   m_strobe = 1'b0;
    bit   m_underrun = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    relay_encode #(.WINDOW(WINDOW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .data_in   (data_in),
        .data_valid(data_valid),
        .in_ready  (in_ready),
        .tx_en     (tx_en),
        .data_out  (data_out),
        .busy      (busy),
        .bit_strobe(bit_strobe),
        .underrun  (underrun),
        .fifo_count(fifo_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each window lasts WINDOW clocks; the next window is chosen from the
    // queue contents as they were before the deciding edge.
    initial forever begin
        bit push_ok;
        bit b;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_active   = 1'b0;
            m_left     = 0;
            m_line     = 1'b0;
            m_strobe   = 1'b0;
            m_underrun = 1'b0;
        end else begin
            push_ok    = data_valid && (m_q.size() != DEPTH);
            m_strobe   = 1'b0;
            m_underrun = 1'b0;
            if (!m_active) begin
                if (tx_en && m_q.size() != 0) begin
                    m_active = 1'b1;
                    m_left   = WINDOW;
                    m_line   = 1'b1;
                end else begin
                    m_line = 1'b0;
                end
            end else if (m_left == 1) begin
                if (!tx_en) begin
                    m_active = 1'b0;
                    m_line   = 1'b0;
                end else begin
                    m_left   = WINDOW;
                    m_strobe = 1'b1;
                    if (m_q.size() != 0) begin
                        b      = m_q.pop_front();
                        m_line = b;
                        exp_q.push_back('{bit_v: b, filler: 1'b0});
                    end else begin
                        m_line     = 1'b0;
                        m_underrun = 1'b1;
                        exp_q.push_back('{bit_v: 1'b0, filler: 1'b1});
                    end
                end
            end else begin
                m_left--;
            end
            if (push_ok) m_q.push_back(data_in[3:2] == 2'b11);
        end
    end

    // Monitor: cycle-level comparison plus scoreboard pop on every DUT window strobe.
    initial forever begin
        win_t e;
        @(negedge clk);
        check("line_data_out", data_out, m_line);
        check("line_busy", busy, m_active);
        check("line_bit_strobe", bit_strobe, m_strobe);
        check("line_underrun", underrun, m_underrun);
        check("line_fifo_count", fifo_count, m_q.size());
        check("line_in_ready", in_ready, m_q.size() != DEPTH);
        if (bit_strobe === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_strobe: got strobe with data_out=%0b expected no window at %0t",
                         data_out, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_bit", data_out, e.bit_v);
                check("sb_underrun", underrun, e.filler);
            end
            if (underrun === 1'b0) n_data_win++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic push_nib(input logic [3:0] d);
        data_in    = d;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        while (!bit_strobe && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, bit_strobe, 1'b1);
    endtask

    task automatic do_reset();
        tx_en      = 1'b0;
        data_valid = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int hi;
        int last;
        int snap;
        bit exp_b[4];
        exp_b = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_bit_strobe", bit_strobe, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_fifo_count", fifo_count, 5'd0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 4'hf pushed with tx_en high: start chip then a 1 window, then fillers
        tx_en      = 1'b1;
        data_in    = 4'hf;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        n = 1;
        while (!data_out && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("first_start_latency", n, 2);
        hi = 0;
        while (data_out && hi < 300) begin
            @(negedge clk);
            hi++;
        end
        check("first_high_length", hi, 2 * WINDOW);
        check("first_filler_underrun", underrun, 1'b1);
        check("first_filler_strobe", bit_strobe, 1'b1);
        repeat (WINDOW + 5) @(negedge clk);
        tx_en = 1'b0;
        wait_idle("first_idle");

        // Four nibbles queued while disabled, then sent as 0,1,0,1
        push_nib(4'h0);
        push_nib(4'hc);
        push_nib(4'h3);
        push_nib(4'hf);
        check("seq_queued", fifo_count, 5'd4);
        tx_en = 1'b1;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_strobe("seq_strobe");
            check("seq_bit", data_out, exp_b[k]);
            if (k > 0) check("seq_spacing", cyc - last, WINDOW);
            last = cyc;
            if (k == 3) tx_en = 1'b0;
            @(negedge clk);
        end
        check("seq_drained", fifo_count, 5'd0);
        wait_idle("seq_idle");

        // Nine pushes into an eight-deep FIFO; the ninth is dropped
        data_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            data_in = 4'($urandom);
            @(negedge clk);
        end
        data_valid = 1'b0;
        check("full_count", fifo_count, 5'(DEPTH));
        check("full_in_ready", in_ready, 1'b0);
        snap  = n_data_win;
        tx_en = 1'b1;
        n = 0;
        while (!(bit_strobe && underrun) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("full_filler_seen", underrun, 1'b1);
        tx_en = 1'b0;
        wait_idle("full_idle");
        check("full_data_windows", n_data_win - snap, DEPTH);

        // tx_en dropped at chip 10 of a data window: window still completes
        push_nib(4'hf);
        push_nib(4'hc);
        tx_en = 1'b1;
        wait_strobe("drop_strobe");
        repeat (10) @(negedge clk);
        tx_en = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drop_remaining_cycles", n, WINDOW - 10);
        check("drop_data_out", data_out, 1'b0);
        tx_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reenable_start", data_out, 1'b1);
        check("reenable_busy", busy, 1'b1);
        wait_strobe("reenable_strobe");
        tx_en = 1'b0;
        wait_idle("reenable_idle");

        // Full FIFO with push held high across the pop edge
        data_valid = 1'b1;
        data_in    = 4'hc;
        repeat (DEPTH + 2) @(negedge clk);
        tx_en = 1'b1;
        wait_strobe("fullpop_strobe");
        check("fullpop_count", fifo_count, 5'(DEPTH - 1));
        check("fullpop_in_ready", in_ready, 1'b1);
        data_valid = 1'b0;
        tx_en      = 1'b0;
        wait_idle("fullpop_idle");

        // Reset at chip 30 of a data window with three bits queued
        do_reset();
        push_nib(4'h3);
        push_nib(4'hf);
        push_nib(4'h0);
        push_nib(4'hc);
        tx_en = 1'b1;
        wait_strobe("rstmid_strobe");
        repeat (30) @(negedge clk);
        check("rstmid_queued", fifo_count, 5'd3);
        #1;
        rst_n = 1'b0;
        tx_en = 1'b0;
        #1;
        check("rstmid_data_out", data_out, 1'b0);
        check("rstmid_fifo_count", fifo_count, 5'd0);
        check("rstmid_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_en = 1'b1;
        push_nib(4'hf);
        @(negedge clk);
        check("rstmid_restart", data_out, 1'b1);
        check("rstmid_restart_strobe", bit_strobe, 1'b0);
        wait_strobe("rstmid_after_strobe");
        tx_en = 1'b0;
        wait_idle("rstmid_idle");

        // Randomized traffic
        tx_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            data_valid = ($urandom_range(0, 99) < 25);
            data_in    = 4'($urandom);
            if ($urandom_range(0, 299) == 0) tx_en = ~tx_en;
            @(negedge clk);
        end
        data_valid = 1'b0;
        tx_en      = 1'b0;
        @(negedge clk);
        wait_idle("final_idle");
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
